alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/reg_decoder_4to16.sv | 12 +
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, ALU op constants and op classification
package cpu_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ROR = 5'b00111;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MDR_RD,
    S_LOAD_Y,
    S_EXEC,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  // Wide ops produce a 2-word result that goes to LO/HI instead of a register.
  function automatic logic is_wide_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// rtl/reg_decoder_4to16.sv - one-hot register strobe decoder from a 4-bit index and enable
module reg_decoder_4to16 #(
  parameter int N = 16
) (
  input  logic [3:0]   idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  assign onehot = en ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle control sequencer driving register/MDR/Y/Z/HI/LO strobes for one ALU instruction
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = OP_W
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPW-1:0]   alu_op,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  input  logic             use_mdr,
  output logic             busy,
  output logic             done,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic             MDRout,
  output logic             MDRin,
  output logic             Read,
  output logic             Yin,
  output logic             Zlowin,
  output logic             ZHighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [OPW-1:0]   op
);

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q;
  logic [3:0]     ra_q, rb_q, rc_q;
  logic           mdr_q;
  logic [3:0]     rout_sel, rin_sel;
  logic           rout_en, rin_en;

  // Outputs are computed for the state being entered, so in IDLE the fresh inputs stand in for the captured fields.
  logic [OPW-1:0] f_op;
  logic [3:0]     f_ra, f_rb, f_rc;
  logic           f_mdr;
  logic           f_wide;

  always_comb begin
    f_op  = (state == S_IDLE) ? alu_op  : op_q;
    f_ra  = (state == S_IDLE) ? ra      : ra_q;
    f_rb  = (state == S_IDLE) ? rb      : rb_q;
    f_rc  = (state == S_IDLE) ? rc      : rc_q;
    f_mdr = (state == S_IDLE) ? use_mdr : mdr_q;
    f_wide = is_wide_op(OP_W'(f_op));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = use_mdr ? S_MDR_RD : S_LOAD_Y;
      S_MDR_RD: state_nxt = S_LOAD_Y;
      S_LOAD_Y: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB_LO;
      S_WB_LO:  state_nxt = f_wide ? S_WB_HI : S_DONE;
      S_WB_HI:  state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      mdr_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rout_sel <= '0;
      rout_en  <= 1'b0;
      rin_sel  <= '0;
      rin_en   <= 1'b0;
      MDRout   <= 1'b0;
      MDRin    <= 1'b0;
      Read     <= 1'b0;
      Yin      <= 1'b0;
      Zlowin   <= 1'b0;
      ZHighin  <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      op       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        op_q  <= alu_op;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
        mdr_q <= use_mdr;
      end
      busy     <= (state_nxt != S_IDLE);
      done     <= 1'b0;
      rout_sel <= '0;
      rout_en  <= 1'b0;
      rin_sel  <= '0;
      rin_en   <= 1'b0;
      MDRout   <= 1'b0;
      MDRin    <= 1'b0;
      Read     <= 1'b0;
      Yin      <= 1'b0;
      Zlowin   <= 1'b0;
      ZHighin  <= 1'b0;
      Zlowout  <= 1'b0;
      Zhighout <= 1'b0;
      HIin     <= 1'b0;
      LOin     <= 1'b0;
      op       <= '0;
      case (state_nxt)
        S_MDR_RD: begin
          Read  <= 1'b1;
          MDRin <= 1'b1;
        end
        S_LOAD_Y: begin
          rout_sel <= f_rb;
          rout_en  <= 1'b1;
          Yin      <= 1'b1;
          op       <= f_op;
        end
        S_EXEC: begin
          if (f_mdr) begin
            MDRout <= 1'b1;
          end else begin
            rout_sel <= f_rc;
            rout_en  <= 1'b1;
          end
          Zlowin  <= 1'b1;
          ZHighin <= 1'b1;
          op      <= f_op;
        end
        S_WB_LO: begin
          Zlowout <= 1'b1;
          op      <= f_op;
          if (f_wide) begin
            LOin <= 1'b1;
          end else begin
            rin_sel <= f_ra;
            rin_en  <= 1'b1;
          end
        end
        S_WB_HI: begin
          Zhighout <= 1'b1;
          HIin     <= 1'b1;
          op       <= f_op;
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

  // Decode from registered index/enable only, so no input reaches the strobes in the same cycle.
  reg_decoder_4to16 #(.N(NREGS)) u_rout_dec (
    .idx    (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_decoder_4to16 #(.N(NREGS)) u_rin_dec (
    .idx    (rin_sel),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench: directed instructions push expected per-cycle strobe words, a monitor compares
module tb_alu_op_sequencer;
  import cpu_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        clear, start, use_mdr;
  logic [4:0]  alu_op;
  logic [3:0]  ra, rb, rc;
  logic        busy, done;
  logic [15:0] Rout, Rin;
  logic        MDRout, MDRin, Read, Yin, Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  op;

  always #5 Clock = ~Clock;

  alu_op_sequencer #(.NREGS(16), .OPW(5)) dut (
    .Clock(Clock), .clear(clear), .start(start), .alu_op(alu_op),
    .ra(ra), .rb(rb), .rc(rc), .use_mdr(use_mdr),
    .busy(busy), .done(done), .Rout(Rout), .Rin(Rin),
    .MDRout(MDRout), .MDRin(MDRin), .Read(Read), .Yin(Yin),
    .Zlowin(Zlowin), .ZHighin(ZHighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .op(op)
  );

  localparam logic [9:0] S_MDROUT = 10'h200, S_MDRIN = 10'h100, S_READ  = 10'h080,
                         S_YIN    = 10'h040, S_ZLIN  = 10'h020, S_ZHIN  = 10'h010,
                         S_ZLOUT  = 10'h008, S_ZHOUT = 10'h004, S_HIIN  = 10'h002,
                         S_LOIN   = 10'h001;
  localparam logic [4:0] OP_ADD = 5'b00011;

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  int          lat_q[$];
  bit          mon_en = 1'b0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  logic [47:0] got;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, want);
    end
  endtask

  task automatic ex(input logic [15:0] r_out, input logic [15:0] r_in, input logic [9:0] str,
                    input logic [4:0] o, input logic dn);
    exp_q.push_back({r_out, r_in, str, o, dn});
  endtask

  always_comb got = {Rout, Rin, MDRout, MDRin, Read, Yin, Zlowin, ZHighin,
                     Zlowout, Zhighout, HIin, LOin, op, done};

  always @(negedge Clock) begin
    if (mon_en) begin
      chk("onehot_rout", 64'($onehot0(Rout)), 64'd1);
      chk("onehot_rin", 64'($onehot0(Rin)), 64'd1);
      chk("single_driver", 64'($onehot0({|Rout, MDRout, Zlowout, Zhighout})), 64'd1);
      if (busy) begin
        busy_cnt++;
        if (exp_q.size() == 0) chk("unexpected_busy_cycle", {16'd0, got}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("strobes", {16'd0, got}, {16'd0, exp_q.pop_front()});
        if (done) begin
          done_cnt++;
          if (lat_q.size() == 0) chk("unexpected_done", 64'(busy_cnt), 64'd0);
          else chk("latency", 64'(busy_cnt), 64'(lat_q.pop_front()));
          busy_cnt = 0;
        end
      end else begin
        busy_cnt = 0;
        chk("idle_zero", {15'd0, got, busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic m);
    alu_op = o; ra = a; rb = b; rc = c; use_mdr = m;
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && lat_q.size() == 0 && !busy) break;
      @(posedge Clock); #1;
    end
    chk({name, "_drain_q"}, 64'(exp_q.size() + lat_q.size()), 64'd0);
    chk({name, "_drain_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic push_ror_reg;
    ex(16'h0008, 16'h0000, S_YIN, OP_ROR, 1'b0);
    ex(16'h0004, 16'h0000, S_ZLIN | S_ZHIN, OP_ROR, 1'b0);
    ex(16'h0000, 16'h0002, S_ZLOUT, OP_ROR, 1'b0);
    ex(16'h0000, 16'h0000, 10'h000, 5'd0, 1'b1);
    lat_q.push_back(4);
  endtask

  int d0;

  initial begin
    clear = 1'b1; start = 1'b0; alu_op = '0; ra = '0; rb = '0; rc = '0; use_mdr = 1'b0;
    repeat (3) @(posedge Clock);
    #1 clear = 1'b0;
    mon_en = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outputs", {16'd0, got}, 64'd0);
    @(posedge Clock); #1;

    push_ror_reg();
    issue(OP_ROR, 4'd1, 4'd3, 4'd2, 1'b0);
    drain("ror_reg");

    ex(16'h0000, 16'h0000, S_READ | S_MDRIN, 5'd0, 1'b0);
    ex(16'h0008, 16'h0000, S_YIN, OP_ROR, 1'b0);
    ex(16'h0000, 16'h0000, S_MDROUT | S_ZLIN | S_ZHIN, OP_ROR, 1'b0);
    ex(16'h0000, 16'h0002, S_ZLOUT, OP_ROR, 1'b0);
    ex(16'h0000, 16'h0000, 10'h000, 5'd0, 1'b1);
    lat_q.push_back(5);
    issue(OP_ROR, 4'd1, 4'd3, 4'd2, 1'b1);
    drain("ror_mdr");

    ex(16'h0010, 16'h0000, S_YIN, OP_MUL, 1'b0);
    ex(16'h0020, 16'h0000, S_ZLIN | S_ZHIN, OP_MUL, 1'b0);
    ex(16'h0000, 16'h0000, S_ZLOUT | S_LOIN, OP_MUL, 1'b0);
    ex(16'h0000, 16'h0000, S_ZHOUT | S_HIIN, OP_MUL, 1'b0);
    ex(16'h0000, 16'h0000, 10'h000, 5'd0, 1'b1);
    lat_q.push_back(5);
    issue(OP_MUL, 4'd1, 4'd4, 4'd5, 1'b0);
    drain("mul_reg");

    ex(16'h0000, 16'h0000, S_READ | S_MDRIN, 5'd0, 1'b0);
    ex(16'h0080, 16'h0000, S_YIN, OP_DIV, 1'b0);
    ex(16'h0000, 16'h0000, S_MDROUT | S_ZLIN | S_ZHIN, OP_DIV, 1'b0);
    ex(16'h0000, 16'h0000, S_ZLOUT | S_LOIN, OP_DIV, 1'b0);
    ex(16'h0000, 16'h0000, S_ZHOUT | S_HIIN, OP_DIV, 1'b0);
    ex(16'h0000, 16'h0000, 10'h000, 5'd0, 1'b1);
    lat_q.push_back(6);
    issue(OP_DIV, 4'd6, 4'd7, 4'd9, 1'b1);
    drain("div_mdr");

    ex(16'h8000, 16'h0000, S_YIN, OP_ADD, 1'b0);
    ex(16'h8000, 16'h0000, S_ZLIN | S_ZHIN, OP_ADD, 1'b0);
    ex(16'h0000, 16'h8000, S_ZLOUT, OP_ADD, 1'b0);
    ex(16'h0000, 16'h0000, 10'h000, 5'd0, 1'b1);
    lat_q.push_back(4);
    issue(OP_ADD, 4'd15, 4'd15, 4'd15, 1'b0);
    drain("same_regs");

    // Abort in EXEC: only LOAD_Y and EXEC words are expected, nothing after.
    ex(16'h0008, 16'h0000, S_YIN, OP_ROR, 1'b0);
    ex(16'h0004, 16'h0000, S_ZLIN | S_ZHIN, OP_ROR, 1'b0);
    issue(OP_ROR, 4'd1, 4'd3, 4'd2, 1'b0);
    @(posedge Clock); #1;
    clear = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0;
    chk("clear_exec_busy", 64'(busy), 64'd0);
    chk("clear_exec_outputs", {16'd0, got}, 64'd0);
    repeat (4) @(posedge Clock);
    #1 chk("clear_exec_queue", 64'(exp_q.size()), 64'd0);

    clear = 1'b1; start = 1'b1; alu_op = OP_ROR; ra = 4'd1; rb = 4'd3; rc = 4'd2; use_mdr = 1'b0;
    @(posedge Clock); #1;
    clear = 1'b0; start = 1'b0;
    chk("clear_start_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge Clock);
    #1 chk("clear_start_idle", 64'(busy), 64'd0);

    for (int k = 0; k < 4; k++) push_ror_reg();
    d0 = done_cnt;
    alu_op = OP_ROR; ra = 4'd1; rb = 4'd3; rc = 4'd2; use_mdr = 1'b0;
    start = 1'b1;
    repeat (20) @(posedge Clock);
    #1 start = 1'b0;
    drain("back_to_back");
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd4);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
